// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: single-clock AXI-Stream FIFO carrying TLAST, with optional
// store-and-forward packet mode that discards packets too large to ever commit.
module axis_pkt_fifo #(
  parameter int DEPTH       = 16,
  parameter int WIDTH       = 8,
  parameter int PACKET_MODE = 1,
  parameter int AF_LEVEL    = DEPTH - 2,
  parameter int AE_LEVEL    = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [AW:0]      count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      pkt_count,
  output logic             drop
);
  typedef enum logic {ACCEPT, DROP} state_t;
  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, pkt_q, pkt_d;
  state_t state_q, state_d;
  logic drop_q, drop_d, full, wr_en, rd_en, oversize;
  assign count = wr_q - rd_q;
  assign full = count == DEPTH[AW:0];
  assign s_axis_tready = state_q == DROP || !full;
  assign wr_en = s_axis_tvalid && s_axis_tready && state_q == ACCEPT;
  assign m_axis_tvalid = PACKET_MODE != 0 ? cm_q != rd_q : count != '0;
  assign rd_en = m_axis_tvalid && m_axis_tready;
  assign {m_axis_tlast, m_axis_tdata} = mem[rd_q[AW-1:0]];
  // full with nothing committed means the open packet can never fit
  assign oversize = PACKET_MODE != 0 && state_q == ACCEPT && full && cm_q == rd_q;
  assign almost_full = count >= AF_LEVEL[AW:0];
  assign almost_empty = count <= AE_LEVEL[AW:0];
  assign pkt_count = pkt_q;
  assign drop = drop_q;
  always_comb begin
    wr_d = oversize ? cm_q : wr_q + (AW+1)'(wr_en);
    cm_d = PACKET_MODE == 0 ? wr_d : (wr_en && s_axis_tlast) ? wr_q + (AW+1)'(1) : cm_q;
    rd_d = rd_q + (AW+1)'(rd_en);
    pkt_d = pkt_q + (AW+1)'(wr_en && s_axis_tlast) - (AW+1)'(rd_en && m_axis_tlast);
    state_d = oversize ? DROP : (state_q == DROP && s_axis_tvalid && s_axis_tlast) ? ACCEPT : state_q;
    drop_d = oversize;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      cm_q <= '0;
      rd_q <= '0;
      pkt_q <= '0;
      state_q <= ACCEPT;
      drop_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      cm_q <= cm_d;
      rd_q <= rd_d;
      pkt_q <= pkt_d;
      state_q <= state_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
endmodule
